// File: rtl/ahb_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// ahb_bus_arbiter_if
// Arbitration handshake between the AHB masters and the bus arbiter.
//   HBUSREQ   per-master bus request
//   HLOCK     per-master lock request
//   HREADY    bus ready from the bridge/slave mux
//   HTRANS    muxed transfer type
//   HBURST    muxed burst type
//   HGRANT    one-hot grant
//   HMASTER   index of the master owning the current address phase
//   HMASTLOCK current address phase belongs to a locked sequence
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface ahb_bus_arbiter_if #(
   parameter int NUM_MASTERS = 2
);
   localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   logic [NUM_MASTERS-1:0] HBUSREQ;
   logic [NUM_MASTERS-1:0] HLOCK;
   logic                   HREADY;
   logic [1:0]             HTRANS;
   logic [2:0]             HBURST;
   logic [NUM_MASTERS-1:0] HGRANT;
   logic [MW-1:0]          HMASTER;
   logic                   HMASTLOCK;

   modport master (
      output HBUSREQ, HLOCK, HREADY, HTRANS, HBURST,
      input  HGRANT, HMASTER, HMASTLOCK
   );

   modport slave (
      input  HBUSREQ, HLOCK, HREADY, HTRANS, HBURST,
      output HGRANT, HMASTER, HMASTLOCK
   );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_bus_arbiter
// Round-robin AHB arbiter sharing the bridge slave port between masters.
// Holds the grant through fixed-length bursts and locked sequences.
// Ports:
//   clk    system clock (HCLK)
//   n_rst  asynchronous active-low reset (HRESETn)
//   bus    arbiter side of ahb_bus_arbiter_if (requests in, grant/master out)
// ---------------------------------------------------------------------------
module ahb_bus_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic                clk,
   input  logic                n_rst,
   ahb_bus_arbiter_if.slave    bus
);
   localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_BUSY   = 2'b01;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   logic [MW-1:0]          owner_q, owner_d;
   logic [MW-1:0]          master_q;
   logic                   mastlock_q;
   logic                   lock_q, lock_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   permit;
   logic [NUM_MASTERS-1:0] grant;

   // Remaining SEQ beats of the current burst.
   always_comb begin
      cnt_d = cnt_q;
      unique case (bus.HTRANS)
         TR_NONSEQ: begin
            unique case (bus.HBURST)
               3'b010, 3'b011: cnt_d = 4'd3;
               3'b100, 3'b101: cnt_d = 4'd7;
               3'b110, 3'b111: cnt_d = 4'd15;
               default:        cnt_d = 4'd0;
            endcase
         end
         TR_SEQ:  cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
         TR_BUSY: cnt_d = cnt_q;
         TR_IDLE: cnt_d = 4'd0;
         default: cnt_d = cnt_q;
      endcase
   end

   // Lock is taken from the pre-edge owner, so an HLOCK rising on the same
   // edge as an otherwise permitted handover still blocks it.
   assign lock_d = bus.HLOCK[owner_q];

   // cnt<=1 lets the old master issue its last SEQ beat while the new
   // grant is already visible.
   assign permit = (cnt_d <= 4'd1) && !lock_d;

   // Round-robin search from owner+1; the owner is checked last, and with
   // no requester the grant parks on the owner.
   always_comb begin
      int  idx;
      logic found;
      owner_d = owner_q;
      found   = 1'b0;
      idx     = 0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         idx = (int'(owner_q) + i) % NUM_MASTERS;
         if (!found && bus.HBUSREQ[idx]) begin
            found   = 1'b1;
            owner_d = MW'(idx);
         end
      end
      if (!permit) begin
         owner_d = owner_q;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         owner_q    <= MW'(DEFAULT_MASTER);
         master_q   <= MW'(DEFAULT_MASTER);
         mastlock_q <= 1'b0;
         lock_q     <= 1'b0;
         cnt_q      <= 4'd0;
      end else if (bus.HREADY) begin
         owner_q    <= owner_d;
         master_q   <= owner_q;
         mastlock_q <= lock_q;
         lock_q     <= lock_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      grant          = '0;
      grant[owner_q] = 1'b1;
   end

   assign bus.HGRANT    = grant;
   assign bus.HMASTER   = master_q;
   assign bus.HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_bus_arbiter
// Directed vectors for the round-robin arbiter with two masters.
// ---------------------------------------------------------------------------
module tb_ahb_bus_arbiter;
   localparam int NM = 2;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;

   logic clk = 1'b0;
   logic n_rst;
   int   n_chk  = 0;
   int   n_fail = 0;

   ahb_bus_arbiter_if #(.NUM_MASTERS(NM)) bus ();

   ahb_bus_arbiter #(.NUM_MASTERS(NM), .DEFAULT_MASTER(0)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [1:0] g, input logic m, input logic ml);
      chk({tag, ".grant"}, 32'(bus.HGRANT), 32'(g));
      chk({tag, ".master"}, 32'(bus.HMASTER), 32'(m));
      chk({tag, ".mastlock"}, 32'(bus.HMASTLOCK), 32'(ml));
   endtask

   always @(negedge clk) begin
      chk("onehot", 32'($onehot(bus.HGRANT)), 32'd1);
   end

   initial begin
      n_rst       = 1'b0;
      bus.HBUSREQ = '0;
      bus.HLOCK   = '0;
      bus.HREADY  = 1'b1;
      bus.HTRANS  = IDLE;
      bus.HBURST  = 3'b000;
      #2;
      chk_out("reset", 2'b01, 1'b0, 1'b0);
      #10;
      n_rst = 1'b1;

      // Park on the default master.
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_out("park", 2'b01, 1'b0, 1'b0);
      end

      // Both request SINGLE transfers: grant alternates, HMASTER trails.
      bus.HBUSREQ = 2'b11;
      bus.HTRANS  = NONSEQ;
      bus.HBURST  = 3'b000;
      tick(); chk_out("alt1", 2'b10, 1'b0, 1'b0);
      tick(); chk_out("alt2", 2'b01, 1'b1, 1'b0);
      tick(); chk_out("alt3", 2'b10, 1'b0, 1'b0);
      tick(); chk_out("alt4", 2'b01, 1'b1, 1'b0);
      bus.HBUSREQ = 2'b01;
      bus.HTRANS  = IDLE;
      tick(); chk_out("alt_end", 2'b01, 1'b0, 1'b0);

      // M0 INCR4, M1 requesting from the NONSEQ cycle.
      bus.HBUSREQ = 2'b11;
      bus.HTRANS  = NONSEQ;
      bus.HBURST  = 3'b011;
      tick(); chk_out("incr4_ns", 2'b01, 1'b0, 1'b0);
      bus.HBUSREQ = 2'b10;
      bus.HTRANS  = SEQ;
      tick(); chk_out("incr4_s1", 2'b01, 1'b0, 1'b0);
      tick(); chk_out("incr4_s2", 2'b10, 1'b0, 1'b0);
      tick(); chk_out("incr4_s3", 2'b10, 1'b1, 1'b0);
      bus.HBUSREQ = 2'b01;
      bus.HTRANS  = IDLE;
      tick(); chk_out("incr4_back", 2'b01, 1'b1, 1'b0);
      tick(); chk_out("incr4_idle", 2'b01, 1'b0, 1'b0);

      // Same burst with two wait states after the first SEQ.
      bus.HBUSREQ = 2'b11;
      bus.HTRANS  = NONSEQ;
      bus.HBURST  = 3'b011;
      tick(); chk_out("ws_ns", 2'b01, 1'b0, 1'b0);
      bus.HBUSREQ = 2'b10;
      bus.HTRANS  = SEQ;
      tick(); chk_out("ws_s1", 2'b01, 1'b0, 1'b0);
      bus.HREADY = 1'b0;
      tick(); chk_out("ws_wait1", 2'b01, 1'b0, 1'b0);
      tick(); chk_out("ws_wait2", 2'b01, 1'b0, 1'b0);
      bus.HREADY = 1'b1;
      tick(); chk_out("ws_s2", 2'b10, 1'b0, 1'b0);
      tick(); chk_out("ws_s3", 2'b10, 1'b1, 1'b0);
      bus.HBUSREQ = 2'b01;
      bus.HTRANS  = IDLE;
      tick(); chk_out("ws_back", 2'b01, 1'b1, 1'b0);
      tick(); chk_out("ws_idle", 2'b01, 1'b0, 1'b0);

      // M1 locked sequence of three transfers while M0 requests.
      bus.HBUSREQ = 2'b10;
      bus.HLOCK   = 2'b10;
      tick(); chk_out("lk_grant", 2'b10, 1'b0, 1'b0);
      bus.HBUSREQ = 2'b11;
      bus.HTRANS  = NONSEQ;
      bus.HBURST  = 3'b000;
      tick(); chk_out("lk_t1", 2'b10, 1'b1, 1'b0);
      tick(); chk_out("lk_t2", 2'b10, 1'b1, 1'b1);
      tick(); chk_out("lk_t3", 2'b10, 1'b1, 1'b1);
      bus.HLOCK = 2'b00;
      tick(); chk_out("lk_release", 2'b01, 1'b1, 1'b1);
      bus.HBUSREQ = 2'b01;
      bus.HTRANS  = IDLE;
      tick(); chk_out("lk_after", 2'b01, 1'b0, 1'b0);

      // Reset in the middle of an INCR8 owned by M1.
      bus.HBUSREQ = 2'b10;
      tick(); chk_out("r8_grant", 2'b10, 1'b0, 1'b0);
      tick(); chk_out("r8_own", 2'b10, 1'b1, 1'b0);
      bus.HBUSREQ = 2'b11;
      bus.HTRANS  = NONSEQ;
      bus.HBURST  = 3'b101;
      tick(); chk_out("r8_ns", 2'b10, 1'b1, 1'b0);
      bus.HTRANS = SEQ;
      tick(); chk_out("r8_s1", 2'b10, 1'b1, 1'b0);
      #2;
      n_rst = 1'b0;
      #1;
      chk_out("r8_async", 2'b01, 1'b0, 1'b0);
      bus.HBUSREQ = 2'b10;
      #2;
      n_rst = 1'b1;
      tick(); chk_out("r8_rearb", 2'b10, 1'b0, 1'b0);
      tick(); chk_out("r8_owner", 2'b10, 1'b1, 1'b0);

      bus.HBUSREQ = 2'b00;
      bus.HTRANS  = IDLE;
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
Round-robin AHB bus arbiter that shares the single AHB slave port of the ahb2apb bridge between several AHB masters (file-reading bus masters, DMA, core). It implements the HBUSREQ/HGRANT/HLOCK handshake. It also drives HMASTER and HMASTLOCK for the external address/write-data multiplexer and the bridge. It honours fixed-length bursts and locked sequences so that the bridge never sees a master switch in the middle of a transaction.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8).
DEFAULT_MASTER, 0, master granted and parked out of reset.
MW, max(1,$clog2(NUM_MASTERS)), width of master index (derived; not overridden).

Ports:
clk  input  1  system clock (HCLK)
n_rst  input  1  asynchronous active-low reset (HRESETn)
HBUSREQ  input  NUM_MASTERS  per-master bus request
HLOCK  input  NUM_MASTERS  per-master lock request
HREADY  input  1  bus ready from the bridge/slave mux; qualifies every state update
HTRANS  input  2  muxed transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
HBURST  input  3  muxed burst type
HGRANT  output  NUM_MASTERS  one-hot grant
HMASTER  output  MW  index of the master owning the current address phase
HMASTLOCK  output  1  current address phase is part of a locked sequence

Behaviour:
- Reset (async, n_rst=0):
  - HGRANT=one-hot(DEFAULT_MASTER), HMASTER=DEFAULT_MASTER, HMASTLOCK=0.
  - Burst counter cnt=0; lock flag=0.
  - Takes effect immediately, including mid-burst; the bench reapplies traffic afterwards.
- All registers update only on a rising clk edge with HREADY=1. With HREADY=0 (wait states) every output and internal register holds.
- Burst counter cnt (4 bits) = SEQ beats still to be issued:
  - HTRANS=NONSEQ with HBURST INCR4/WRAP4 (011/010): load 3.
  - HTRANS=NONSEQ with HBURST INCR8/WRAP8 (101/100): load 7.
  - HTRANS=NONSEQ with HBURST INCR16/WRAP16 (111/110): load 15.
  - HTRANS=NONSEQ with SINGLE/INCR: load 0.
  - HTRANS=SEQ with cnt>0: decrement.
  - HTRANS=BUSY: hold.
  - HTRANS=IDLE: clear to 0 (covers bursts aborted after an ERROR response).
- Lock: the lock flag is set while HLOCK[owner]=1, where owner is the currently granted master.
- Re-arbitration is permitted at an HREADY edge iff both hold:
  - the cnt value after that edge is <=1;
  - the lock flag is 0.
  - While re-arbitration is blocked, HGRANT holds even if the owner drops HBUSREQ.
- Round-robin selection when permitted:
  - Search HBUSREQ starting at owner+1, wrapping modulo NUM_MASTERS; the owner itself is checked last.
  - The first requester found gets HGRANT.
  - If no master requests, HGRANT stays on the current owner (park).
- HMASTER/HMASTLOCK pipeline:
  - At each HREADY edge, HMASTER <= index(HGRANT) as it was before the edge, and HMASTLOCK <= lock flag.
  - HMASTER therefore lags HGRANT by exactly one HREADY-qualified cycle (the standard AHB grant-to-address-phase handover).
  - The cnt<=1 rule lets the old master issue its final SEQ beat before HMASTER switches.
- Grant switch latency: a new request is granted at the first permitted HREADY edge. With back-to-back HREADY=1, the new master owns the address phase one cycle after that.
- Simultaneous events:
  - A request arriving on the same edge the owner completes its burst is eligible.
  - An HLOCK rising on the same edge as a permitted re-arbitration blocks it (lock is evaluated against the pre-edge owner).
- HGRANT is always exactly one-hot; the bench asserts this every cycle.

Test Plan:
- Reset, no requests -> HGRANT=01, HMASTER=0, HMASTLOCK=0; parks there for 10 cycles with HREADY=1.
- M0 and M1 request continuously, SINGLE transfers, HREADY=1 -> HGRANT alternates 01,10,01 each cycle; HMASTER follows one cycle later.
- M0 issues INCR4 (NONSEQ + 3 SEQ) while M1 requests from the NONSEQ cycle -> HGRANT moves to M1 at the edge after the 2nd SEQ (cnt->1); HMASTER=1 only after the 3rd SEQ is accepted.
- Repeat the INCR4 case with HREADY=0 for 2 cycles inside the burst -> grant handover is delayed by exactly 2 cycles; no premature switch.
- M1 holds HLOCK=1 for 3 transfers while M0 requests -> HGRANT stays 10 and HMASTLOCK=1; after HLOCK drops, M0 is granted at the next HREADY edge.
- n_rst asserted mid-INCR8 owned by M1 -> outputs immediately return to HGRANT=01, HMASTER=0, HMASTLOCK=0; cnt=0, verified via an immediate re-arbitration after release.
